// File: rtl/cop_spi_master_pkg.sv
// rtl/cop_spi_master_pkg.sv - shared device select codes, widths and FSM state type for the coprocessor SPI master
package cop_spi_master_pkg;

   localparam int COP_DEV_W  = 3;
   localparam int COP_BYTE_W = 8;

   localparam logic [COP_DEV_W-1:0] DEV_SELECT_NONE   = 3'd0;
   localparam logic [COP_DEV_W-1:0] DEV_SELECT_LOGIC  = 3'd1;
   localparam logic [COP_DEV_W-1:0] DEV_SELECT_SDCARD = 3'd2;
   localparam logic [COP_DEV_W-1:0] DEV_SELECT_USB    = 3'd3;
   localparam logic [COP_DEV_W-1:0] DEV_SELECT_FPGA   = 3'd4;
   localparam logic [COP_DEV_W-1:0] DEV_SELECT_FLASH  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SWITCH,
      ST_SETUP,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_GAP,
      ST_RELEASE
   } spi_state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - D-cycle phase down-counter; ticks in the last cycle of a phase
module spi_phase_timer #(
   parameter int D = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_tick
);
   localparam logic [7:0] RELOAD = 8'(D - 1);

   logic [7:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= 8'd0;
      end else if (i_restart) begin
         r_cnt <= RELOAD;
      end else if (r_cnt != 8'd0) begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   assign o_tick = (r_cnt == 8'd0);

endmodule

// File: rtl/cop_spi_master.sv
// rtl/cop_spi_master.sv - coprocessor-side mode-0 SPI master with per-device select framing
// Byte requests arrive on a valid/ready handshake; select may be held across back-to-back bytes.
module cop_spi_master
   import cop_spi_master_pkg::*;
#(
   parameter int CLK_DIV          = 4,
   parameter int DEV_SELECT_WIDTH = COP_DEV_W,
   parameter int BYTE_WIDTH       = COP_BYTE_W
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic [BYTE_WIDTH-1:0]       i_tx_data,
   input  logic [DEV_SELECT_WIDTH-1:0] i_tx_dev,
   input  logic                        i_tx_hold,
   input  logic                        i_tx_valid,
   output logic                        o_tx_ready,
   output logic [BYTE_WIDTH-1:0]       o_rx_data,
   output logic                        o_rx_valid,
   output logic                        o_busy,
   output logic [DEV_SELECT_WIDTH-1:0] o_cop_select,
   output logic                        o_cop_sck,
   output logic                        o_cop_mosi,
   input  logic                        i_cop_miso
);
   localparam logic [DEV_SELECT_WIDTH-1:0] SEL_NONE = DEV_SELECT_WIDTH'(DEV_SELECT_NONE);
   localparam logic [2:0]                  BIT_MSB  = 3'(BYTE_WIDTH - 1);

   spi_state_t                  r_state, w_state_nxt;
   logic [DEV_SELECT_WIDTH-1:0] r_sel, w_sel_nxt;
   logic [DEV_SELECT_WIDTH-1:0] r_dev, w_dev_nxt;
   logic                        r_held, w_held_nxt;
   logic                        r_hold, w_hold_nxt;
   logic [BYTE_WIDTH-1:0]       r_tx, w_tx_nxt;
   logic [2:0]                  r_bit, w_bit_nxt;
   logic                        r_sck, w_sck_nxt;
   logic                        r_mosi, w_mosi_nxt;
   logic [BYTE_WIDTH-1:0]       r_rx_shift, w_rx_shift_nxt;
   logic [BYTE_WIDTH-1:0]       r_rx_data, w_rx_data_nxt;
   logic                        r_rx_valid, w_rx_valid_nxt;
   logic                        w_tick, w_restart, w_ready, w_accept, w_sel_kept;

   spi_phase_timer #(.D(CLK_DIV)) u_timer (
      .i_clk     (i_clk),
      .i_rst     (i_reset),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   // Only the last GAP cycle of a held byte can take the next byte without a select gap.
   assign w_ready    = (r_state == ST_IDLE) || ((r_state == ST_GAP) && w_tick && r_hold);
   assign w_accept   = i_tx_valid && w_ready;
   assign w_sel_kept = (r_state == ST_GAP) ? r_hold : r_held;
   assign w_restart  = (w_state_nxt != r_state);

   always_comb begin
      w_state_nxt    = r_state;
      w_sel_nxt      = r_sel;
      w_dev_nxt      = r_dev;
      w_held_nxt     = r_held;
      w_hold_nxt     = r_hold;
      w_tx_nxt       = r_tx;
      w_bit_nxt      = r_bit;
      w_sck_nxt      = r_sck;
      w_mosi_nxt     = r_mosi;
      w_rx_shift_nxt = r_rx_shift;
      w_rx_data_nxt  = r_rx_data;
      w_rx_valid_nxt = 1'b0;

      if (w_accept) begin
         w_tx_nxt   = i_tx_data;
         w_dev_nxt  = i_tx_dev;
         w_hold_nxt = i_tx_hold;
         w_bit_nxt  = BIT_MSB;
         if (!w_sel_kept) begin
            w_state_nxt = ST_SETUP;
            w_sel_nxt   = i_tx_dev;
         end else if (i_tx_dev == r_sel) begin
            w_state_nxt = ST_SHIFT_LO;
         end else begin
            w_state_nxt = ST_SWITCH;
            w_sel_nxt   = SEL_NONE;
         end
      end else begin
         unique case (r_state)
            ST_IDLE: ;
            ST_SWITCH: if (w_tick) begin
               w_state_nxt = ST_SETUP;
               w_sel_nxt   = r_dev;
            end
            ST_SETUP: if (w_tick) begin
               w_state_nxt = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: if (w_tick) begin
               w_state_nxt    = ST_SHIFT_HI;
               w_sck_nxt      = 1'b1;
               w_rx_shift_nxt = {r_rx_shift[BYTE_WIDTH-2:0], i_cop_miso};
            end
            ST_SHIFT_HI: if (w_tick) begin
               w_sck_nxt = 1'b0;
               if (r_bit == 3'd0) begin
                  w_state_nxt    = ST_GAP;
                  w_rx_data_nxt  = r_rx_shift;
                  w_rx_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_SHIFT_LO;
                  w_bit_nxt   = r_bit - 3'd1;
               end
            end
            ST_GAP: if (w_tick) begin
               if (r_hold) begin
                  w_state_nxt = ST_IDLE;
                  w_held_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_RELEASE;
                  w_sel_nxt   = SEL_NONE;
                  w_held_nxt  = 1'b0;
               end
            end
            ST_RELEASE: if (w_tick) begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end

      if (w_state_nxt == ST_SHIFT_LO) begin
         w_mosi_nxt = w_tx_nxt[w_bit_nxt];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_sel      <= SEL_NONE;
         r_dev      <= SEL_NONE;
         r_held     <= 1'b0;
         r_hold     <= 1'b0;
         r_tx       <= '0;
         r_bit      <= 3'd0;
         r_sck      <= 1'b0;
         r_mosi     <= 1'b0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_dev      <= w_dev_nxt;
         r_held     <= w_held_nxt;
         r_hold     <= w_hold_nxt;
         r_tx       <= w_tx_nxt;
         r_bit      <= w_bit_nxt;
         r_sck      <= w_sck_nxt;
         r_mosi     <= w_mosi_nxt;
         r_rx_shift <= w_rx_shift_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_rx_valid <= w_rx_valid_nxt;
      end
   end

   assign o_tx_ready   = w_ready && !i_reset;
   assign o_rx_data    = r_rx_data;
   assign o_rx_valid   = r_rx_valid;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_cop_select = r_sel;
   assign o_cop_sck    = r_sck;
   assign o_cop_mosi   = r_mosi;

endmodule

// File: tb/tb_cop_spi_master.sv
// tb/tb_cop_spi_master.sv - self-checking bench for cop_spi_master
module tb_cop_spi_master;
   import cop_spi_master_pkg::*;

   localparam int D = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic [2:0] tx_dev;
   logic       tx_hold;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic [2:0] cop_select;
   logic       cop_sck;
   logic       cop_mosi;
   logic       cop_miso;
   logic       miso_rand = 1'b0;
   int         mode;

   int checks   = 0;
   int failures = 0;

   cop_spi_master #(.CLK_DIV(D)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_tx_data    (tx_data),
      .i_tx_dev     (tx_dev),
      .i_tx_hold    (tx_hold),
      .i_tx_valid   (tx_valid),
      .o_tx_ready   (tx_ready),
      .o_rx_data    (rx_data),
      .o_rx_valid   (rx_valid),
      .o_busy       (busy),
      .o_cop_select (cop_select),
      .o_cop_sck    (cop_sck),
      .o_cop_mosi   (cop_mosi),
      .i_cop_miso   (cop_miso)
   );

   always #5 clk = ~clk;

   // Slave: loopback, inverting, or a random bit changed on each sck fall.
   assign cop_miso = (mode == 0) ? cop_mosi : (mode == 1) ? ~cop_mosi : miso_rand;
   always @(negedge cop_sck) miso_rand = 1'($urandom);

   int         cyc = 0;
   int         rise_cyc[$];
   logic       mosi_q[$];
   logic       miso_q[$];
   int         rx_cyc[$];
   logic [7:0] rx_q[$];
   logic [2:0] sel_q[$];
   int         sel_cyc[$];
   logic       prev_sck = 1'b0;
   logic [2:0] prev_sel = 3'd0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cop_sck && !prev_sck) begin
         rise_cyc.push_back(cyc);
         mosi_q.push_back(cop_mosi);
         miso_q.push_back(cop_miso);
      end
      if (rx_valid) begin
         rx_cyc.push_back(cyc);
         rx_q.push_back(rx_data);
      end
      if (cop_select != prev_sel) begin
         sel_q.push_back(cop_select);
         sel_cyc.push_back(cyc);
      end
      prev_sck = cop_sck;
      prev_sel = cop_select;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [2:0] dev, input logic hold, output int acc);
      int n = 0;
      tx_data  = d;
      tx_dev   = dev;
      tx_hold  = hold;
      tx_valid = 1'b1;
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_time", (n < 1000) ? 1 : 0, 1);
      @(posedge clk);
      @(negedge clk);
      acc      = cyc;
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int nrx);
      int n = 0;
      while ((busy || rx_q.size() < nrx) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("idle_in_time", (n < 3000) ? 1 : 0, 1);
   endtask

   logic [7:0] exp_tx[$];

   task automatic verify(input string tag, input int r0, input int x0, input int md);
      logic [7:0] mo, mi, want;
      int nb = exp_tx.size();
      check({tag, "_rx_count"}, rx_q.size() - x0, nb);
      check({tag, "_sck_rises"}, rise_cyc.size() - r0, 8 * nb);
      if (rx_q.size() - x0 == nb && rise_cyc.size() - r0 == 8 * nb) begin
         for (int k = 0; k < nb; k++) begin
            mo = 8'h00;
            mi = 8'h00;
            for (int i = 0; i < 8; i++) begin
               mo = {mo[6:0], mosi_q[r0 + 8 * k + i]};
               mi = {mi[6:0], miso_q[r0 + 8 * k + i]};
            end
            want = (md == 0) ? exp_tx[k] : (md == 1) ? ~exp_tx[k] : mi;
            check({tag, "_mosi"}, mo, exp_tx[k]);
            check({tag, "_rx_data"}, rx_q[x0 + k], want);
         end
      end
   endtask

   int         acc, acc2, r0, x0, s0, n;
   logic       held;
   logic [2:0] cur_dev, rdev;
   logic [7:0] rdata;
   logic       rhold;
   int         lat;

   initial begin
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_dev   = 3'd0;
      tx_hold  = 1'b0;
      mode     = 0;
      #2;
      check("rst_select", cop_select, DEV_SELECT_NONE);
      check("rst_sck", cop_sck, 0);
      check("rst_mosi", cop_mosi, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_tx_ready", tx_ready, 1);

      // 1: loopback 0xA5 to LOGIC, plus a request while busy that must be ignored
      mode = 0;
      r0 = rise_cyc.size(); x0 = rx_q.size(); s0 = sel_q.size();
      exp_tx.delete(); exp_tx.push_back(8'hA5);
      send(8'hA5, DEV_SELECT_LOGIC, 1'b0, acc);
      @(negedge clk);
      tx_data = 8'h77; tx_dev = DEV_SELECT_USB; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_idle(x0 + 1);
      verify("t1", r0, x0, 0);
      check("t1_rx_latency", rx_cyc[x0] - acc, 17 * D);
      check("t1_first_rise", rise_cyc[r0] - acc, 2 * D);
      check("t1_sel_changes", sel_q.size() - s0, 2);
      check("t1_sel_assert", sel_q[s0], DEV_SELECT_LOGIC);
      check("t1_sel_assert_cyc", sel_cyc[s0] - acc, 0);
      check("t1_sel_release", sel_q[s0 + 1], DEV_SELECT_NONE);
      check("t1_sel_release_cyc", sel_cyc[s0 + 1] - acc, 18 * D);

      // 2: inverting slave
      mode = 1;
      r0 = rise_cyc.size(); x0 = rx_q.size();
      exp_tx.delete(); exp_tx.push_back(8'h3C);
      send(8'h3C, DEV_SELECT_LOGIC, 1'b0, acc);
      wait_idle(x0 + 1);
      verify("t2", r0, x0, 1);

      // 3: three back-to-back bytes with select held
      mode = 0;
      r0 = rise_cyc.size(); x0 = rx_q.size(); s0 = sel_q.size();
      exp_tx.delete(); exp_tx.push_back(8'h01); exp_tx.push_back(8'h02); exp_tx.push_back(8'h04);
      send(8'h01, DEV_SELECT_LOGIC, 1'b1, acc);
      send(8'h02, DEV_SELECT_LOGIC, 1'b1, acc2);
      send(8'h04, DEV_SELECT_LOGIC, 1'b0, acc2);
      wait_idle(x0 + 3);
      verify("t3", r0, x0, 0);
      check("t3_sel_changes", sel_q.size() - s0, 2);
      check("t3_sel_last", sel_q[sel_q.size() - 1], DEV_SELECT_NONE);
      check("t3_gap_rise_to_rise", rise_cyc[r0 + 8] - rise_cyc[r0 + 7], 3 * D);
      check("t3_rx_spacing", rx_cyc[x0 + 1] - rx_cyc[x0], 17 * D);

      // 4: held SDCARD then FLASH forces a select switch
      mode = 2;
      r0 = rise_cyc.size(); x0 = rx_q.size(); s0 = sel_q.size();
      rdata = 8'($urandom);
      exp_tx.delete(); exp_tx.push_back(rdata); exp_tx.push_back(8'hC9);
      send(rdata, DEV_SELECT_SDCARD, 1'b1, acc);
      send(8'hC9, DEV_SELECT_FLASH, 1'b0, acc2);
      wait_idle(x0 + 2);
      verify("t4", r0, x0, 2);
      check("t4_sel_changes", sel_q.size() - s0, 4);
      check("t4_sel0", sel_q[s0], DEV_SELECT_SDCARD);
      check("t4_sel1", sel_q[s0 + 1], DEV_SELECT_NONE);
      check("t4_sel2", sel_q[s0 + 2], DEV_SELECT_FLASH);
      check("t4_switch_len", sel_cyc[s0 + 2] - sel_cyc[s0 + 1], D);

      // 5: reset during bit 4 of 0xFF
      mode = 0;
      r0 = rise_cyc.size(); x0 = rx_q.size();
      send(8'hFF, DEV_SELECT_LOGIC, 1'b0, acc);
      n = 0;
      while (rise_cyc.size() - r0 < 4 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("t5_reach_bit4", (n < 500) ? 1 : 0, 1);
      check("t5_busy_before", busy, 1);
      #1 rst = 1'b1;
      #1;
      check("t5_select", cop_select, DEV_SELECT_NONE);
      check("t5_sck", cop_sck, 0);
      check("t5_mosi", cop_mosi, 0);
      check("t5_rx_data", rx_data, 0);
      check("t5_tx_ready", tx_ready, 0);
      check("t5_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_no_rx_valid", rx_q.size() - x0, 0);
      r0 = rise_cyc.size(); x0 = rx_q.size();
      exp_tx.delete(); exp_tx.push_back(8'h55);
      send(8'h55, DEV_SELECT_LOGIC, 1'b0, acc);
      wait_idle(x0 + 1);
      verify("t5b", r0, x0, 0);
      check("t5b_latency", rx_cyc[x0] - acc, 17 * D);

      // 6: dummy clocks with no device selected
      mode = 0;
      r0 = rise_cyc.size(); x0 = rx_q.size(); s0 = sel_q.size();
      exp_tx.delete(); exp_tx.push_back(8'hFF);
      send(8'hFF, DEV_SELECT_NONE, 1'b0, acc);
      wait_idle(x0 + 1);
      verify("t6", r0, x0, 0);
      check("t6_sel_untouched", sel_q.size() - s0, 0);
      check("t6_latency", rx_cyc[x0] - acc, 17 * D);

      // Random bytes; latency predicted from whether select is held and matches
      held = 1'b0;
      cur_dev = DEV_SELECT_NONE;
      for (int it = 0; it < 12; it++) begin
         mode  = int'($urandom_range(0, 2));
         rdev  = 3'($urandom_range(1, 5));
         rdata = 8'($urandom);
         rhold = (it == 11) ? 1'b0 : 1'($urandom);
         lat   = !held ? 17 * D : (rdev == cur_dev) ? 16 * D : 18 * D;
         r0 = rise_cyc.size(); x0 = rx_q.size();
         exp_tx.delete(); exp_tx.push_back(rdata);
         send(rdata, rdev, rhold, acc);
         wait_idle(x0 + 1);
         verify("rand", r0, x0, mode);
         if (rx_q.size() > x0) check("rand_latency", rx_cyc[x0] - acc, lat);
         check("rand_select", cop_select, rhold ? rdev : DEV_SELECT_NONE);
         held    = rhold;
         cur_dev = rdev;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
